// File: rtl/gon_pkg.sv
// Shared definitions for the gather-on-network (GON) block.
package gon_pkg;

  localparam int GON_ROWS       = 4;
  localparam int GON_COLS       = 4;
  localparam int GON_DATA_BITS  = 32;
  localparam int GON_XID_BITS   = 4;
  localparam int GON_YID_BITS   = 3;
  localparam int GON_FIFO_DEPTH = 4;

  typedef enum logic {
    GON_MODE_TAG  = 1'b0,
    GON_MODE_SCAN = 1'b1
  } gon_mode_e;

endpackage

// File: rtl/gon_row_fifo.sv
// Per-row first-word-fall-through buffer; the head entry is always visible on data_o.
module gon_row_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/gon_gather.sv
// Gathers PE words row-by-row into per-row FIFOs, then round-robins the rows
// into a single registered GLB-side output stage.
module gon_gather
  import gon_pkg::*;
#(
  parameter int ROWS       = GON_ROWS,
  parameter int COLS       = GON_COLS,
  parameter int DATA_BITS  = GON_DATA_BITS,
  parameter int XID_BITS   = GON_XID_BITS,
  parameter int YID_BITS   = GON_YID_BITS,
  parameter int FIFO_DEPTH = GON_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mode,
  input  logic [XID_BITS-1:0]           tag_X,
  input  logic [YID_BITS-1:0]           tag_Y,
  input  logic                          set_XID,
  input  logic [XID_BITS-1:0]           XID_scan_in,
  input  logic                          set_YID,
  input  logic [YID_BITS-1:0]           YID_scan_in,
  input  logic [ROWS*COLS-1:0]          PE_valid,
  input  logic [DATA_BITS*ROWS*COLS-1:0] PE_data,
  output logic [ROWS*COLS-1:0]          PE_ready,
  output logic                          GON_valid,
  output logic [DATA_BITS-1:0]          GON_data,
  input  logic                          GON_ready,
  output logic [$clog2(ROWS)-1:0]       GON_src_row,
  output logic [$clog2(COLS)-1:0]       GON_src_col,
  output logic                          busy
);

  localparam int N  = ROWS * COLS;
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int FW = DATA_BITS + CW;

  gon_mode_e mode_e;
  logic      scan;
  assign mode_e = gon_mode_e'(mode);
  assign scan   = (mode_e == GON_MODE_SCAN);

  logic [XID_BITS-1:0] xid_q [N];
  logic [YID_BITS-1:0] yid_q [ROWS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++)    xid_q[k] <= '0;
      for (int k = 0; k < ROWS; k++) yid_q[k] <= '0;
    end else begin
      if (set_XID) begin
        xid_q[0] <= XID_scan_in;
        for (int k = 1; k < N; k++) xid_q[k] <= xid_q[k-1];
      end
      if (set_YID) begin
        yid_q[0] <= YID_scan_in;
        for (int k = 1; k < ROWS; k++) yid_q[k] <= yid_q[k-1];
      end
    end
  end

  logic [N-1:0]    elig;
  logic [CW-1:0]   col_rr_q [ROWS];
  logic [CW-1:0]   gnt_col  [ROWS];
  logic [ROWS-1:0] gnt_any;
  logic [ROWS-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [FW-1:0]   fifo_din  [ROWS];
  logic [FW-1:0]   fifo_dout [ROWS];

  always_comb begin
    elig = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        elig[r*COLS+c] = PE_valid[r*COLS+c] &&
                         (scan || ((xid_q[r*COLS+c] == tag_X) && (yid_q[r] == tag_Y)));
      end
    end
  end

  // TAG searches from col 0 (lowest wins); SCAN searches from the row's RR pointer.
  always_comb begin
    int c;
    c       = 0;
    gnt_any = '0;
    for (int r = 0; r < ROWS; r++) begin
      gnt_col[r] = '0;
      for (int i = 0; i < COLS; i++) begin
        c = scan ? (int'(col_rr_q[r]) + i) % COLS : i;
        if (!gnt_any[r] && elig[r*COLS+c]) begin
          gnt_any[r] = 1'b1;
          gnt_col[r] = CW'(c);
        end
      end
    end
  end

  always_comb begin
    PE_ready  = '0;
    fifo_push = '0;
    for (int r = 0; r < ROWS; r++) begin
      fifo_push[r] = !rst && gnt_any[r] && !fifo_full[r];
      fifo_din[r]  = {PE_data[(r*COLS + int'(gnt_col[r]))*DATA_BITS +: DATA_BITS], gnt_col[r]};
      for (int c = 0; c < COLS; c++) begin
        PE_ready[r*COLS+c] = fifo_push[r] && (gnt_col[r] == CW'(c));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) col_rr_q[r] <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (scan && fifo_push[r])
          col_rr_q[r] <= (gnt_col[r] == CW'(COLS-1)) ? '0 : gnt_col[r] + CW'(1);
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    gon_row_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push[r]),
      .data_i  (fifo_din[r]),
      .pop_i   (fifo_pop[r]),
      .data_o  (fifo_dout[r]),
      .full_o  (fifo_full[r]),
      .empty_o (fifo_empty[r])
    );
  end

  logic [RW-1:0]        row_rr_q, sel_row;
  logic                 sel_any, pop_en;
  logic                 gon_valid_q;
  logic [DATA_BITS-1:0] gon_data_q;
  logic [RW-1:0]        src_row_q;
  logic [CW-1:0]        src_col_q;

  always_comb begin
    int rr;
    rr      = 0;
    sel_any = 1'b0;
    sel_row = '0;
    for (int i = 0; i < ROWS; i++) begin
      rr = (int'(row_rr_q) + i) % ROWS;
      if (!sel_any && !fifo_empty[rr]) begin
        sel_any = 1'b1;
        sel_row = RW'(rr);
      end
    end
  end

  assign pop_en = sel_any && (!gon_valid_q || GON_ready);

  always_comb begin
    fifo_pop = '0;
    for (int r = 0; r < ROWS; r++) fifo_pop[r] = pop_en && (sel_row == RW'(r));
  end

  // Output stage only reloads when empty or being consumed, so it holds under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      gon_valid_q <= 1'b0;
      gon_data_q  <= '0;
      src_row_q   <= '0;
      src_col_q   <= '0;
      row_rr_q    <= '0;
    end else if (!gon_valid_q || GON_ready) begin
      gon_valid_q <= sel_any;
      if (sel_any) begin
        gon_data_q <= fifo_dout[sel_row][FW-1:CW];
        src_col_q  <= fifo_dout[sel_row][CW-1:0];
        src_row_q  <= sel_row;
        row_rr_q   <= (sel_row == RW'(ROWS-1)) ? '0 : sel_row + RW'(1);
      end
    end
  end

  assign GON_valid   = gon_valid_q;
  assign GON_data    = gon_data_q;
  assign GON_src_row = src_row_q;
  assign GON_src_col = src_col_q;
  assign busy        = (|(~fifo_empty)) || gon_valid_q;

endmodule
